// File: rtl/permute_burst_dispatcher.sv
// Buffers {bot, validPerms, batchDone} entries and expands each into one beat per set mask bit.
// First beat one cycle after pop; downstreamStall freezes the burst and blocks pops.

module permute_burst_fifo #(
   parameter int W          = 8,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en_i,
   input  logic [W-1:0]        wr_dat_i,
   input  logic                rd_en_i,
   output logic [W-1:0]        rd_dat_o,
   output logic                empty_o,
   output logic                full_o,
   output logic [DEPTH_LOG2:0] usedw_o
);
   localparam int DEPTH = 2**DEPTH_LOG2;

   logic [W-1:0]          mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  rd_ok, wr_ok;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign rd_ok    = rd_en_i && !empty_o;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_ok    = wr_en_i && (!full_o || rd_ok);
   assign rd_dat_o = mem_q[rd_ptr_q];
   assign usedw_o  = count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
         else if (rd_ok && !wr_ok) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
   end
endmodule

module permute_burst_dispatcher #(
   parameter int DATA_WIDTH      = 128,
   parameter int PERM_COUNT      = 6,
   parameter int FIFO_DEPTH_LOG2 = 5,
   parameter int SLOWDOWN_THRESH = 24,
   parameter int MAX_BATCHES     = 256,
   localparam int PIDX_W = (PERM_COUNT > 1) ? $clog2(PERM_COUNT) : 1,
   localparam int CRED_W = $clog2(MAX_BATCHES + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       writeData,
   input  logic [DATA_WIDTH-1:0]      botIn,
   input  logic [PERM_COUNT-1:0]      validPermsIn,
   input  logic                       batchDoneIn,
   output logic                       slowDownInput,
   output logic [FIFO_DEPTH_LOG2:0]   fifoUsedw,
   input  logic                       downstreamStall,
   output logic                       outValid,
   output logic [DATA_WIDTH-1:0]      outBot,
   output logic [PIDX_W-1:0]          outPermIdx,
   output logic                       outLastOfBatch,
   input  logic                       resultRetired,
   output logic [CRED_W-1:0]          batchesInFlight,
   output logic [1:0]                 errorSticky
);
   typedef struct packed {
      logic                  done;
      logic [PERM_COUNT-1:0] mask;
      logic [DATA_WIDTH-1:0] bot;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);

   typedef enum logic {IDLE, BURST} state_t;

   function automatic logic [PIDX_W-1:0] low_idx(input logic [PERM_COUNT-1:0] m);
      low_idx = '0;
      for (int i = PERM_COUNT - 1; i >= 0; i--) begin
         if (m[i]) low_idx = PIDX_W'(i);
      end
   endfunction

   state_t                state_q, state_d;
   entry_t                burst_q, burst_d, head, src;
   logic [ENTRY_W-1:0]    fifo_rd_dat;
   logic                  fifo_empty, fifo_full;
   logic [PERM_COUNT-1:0] rem;
   logic                  wr_req, pop, emit, in_burst, credit_ok, take;
   logic                  vld_q, vld_d, last_q, last_d, slow_q, slow_d;
   logic [DATA_WIDTH-1:0] bot_q, bot_d;
   logic [PIDX_W-1:0]     idx_q, idx_d;
   logic [CRED_W-1:0]     cred_q, cred_d;
   logic [1:0]            err_q, err_d;

   assign wr_req = writeData && (|validPermsIn || batchDoneIn);

   permute_burst_fifo #(.W(ENTRY_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (wr_req),
      .wr_dat_i ({batchDoneIn, validPermsIn, botIn}),
      .rd_en_i  (pop),
      .rd_dat_o (fifo_rd_dat),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full),
      .usedw_o  (fifoUsedw)
   );

   assign head      = fifo_rd_dat;
   assign in_burst  = (state_q == BURST);
   // In IDLE the popped head is expanded directly so its first beat lands one cycle after pop.
   assign src       = in_burst ? burst_q : head;
   assign rem       = src.mask & (src.mask - 1'b1);
   assign credit_ok = !(head.done && cred_q == CRED_W'(MAX_BATCHES));
   assign pop       = !fifo_empty && !downstreamStall && credit_ok && (!in_burst || rem == '0);
   assign emit      = !downstreamStall && (in_burst || pop);
   assign take      = pop && head.done;

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      bot_d   = bot_q;
      idx_d   = idx_q;
      if (emit) begin
         vld_d  = |src.mask;
         last_d = src.done && (rem == '0);
         if (|src.mask) begin
            bot_d = src.bot;
            idx_d = low_idx(src.mask);
         end
         if (rem != '0) begin
            state_d = BURST;
            burst_d = '{done: src.done, mask: rem, bot: src.bot};
         end else if (in_burst && pop) begin
            state_d = BURST;
            burst_d = head;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      cred_d = cred_q;
      err_d  = err_q;
      slow_d = (fifoUsedw > (FIFO_DEPTH_LOG2+1)'(SLOWDOWN_THRESH));
      if (wr_req && fifo_full && !pop) err_d[0] = 1'b1;
      if (take && !resultRetired) begin
         cred_d = cred_q + 1'b1;
      end else if (!take && resultRetired) begin
         if (cred_q == '0) err_d[1] = 1'b1;
         else              cred_d = cred_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         burst_q <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         bot_q   <= '0;
         idx_q   <= '0;
         cred_q  <= '0;
         err_q   <= '0;
         slow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         bot_q   <= bot_d;
         idx_q   <= idx_d;
         cred_q  <= cred_d;
         err_q   <= err_d;
         slow_q  <= slow_d;
      end
   end

   assign outValid        = vld_q;
   assign outLastOfBatch  = last_q;
   assign outBot          = bot_q;
   assign outPermIdx      = idx_q;
   assign batchesInFlight = cred_q;
   assign errorSticky     = err_q;
   assign slowDownInput   = slow_q;
endmodule

// File: tb/tb_permute_burst_dispatcher.sv
// Scoreboard bench for permute_burst_dispatcher with MAX_BATCHES=2 so credit exhaustion is reachable.
module tb_permute_burst_dispatcher;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         writeData = 1'b0;
   logic [127:0] botIn = '0;
   logic [5:0]   validPermsIn = '0;
   logic         batchDoneIn = 1'b0;
   logic         slowDownInput;
   logic [5:0]   fifoUsedw;
   logic         downstreamStall = 1'b0;
   logic         outValid;
   logic [127:0] outBot;
   logic [2:0]   outPermIdx;
   logic         outLastOfBatch;
   logic         resultRetired = 1'b0;
   logic [1:0]   batchesInFlight;
   logic [1:0]   errorSticky;

   permute_burst_dispatcher #(.MAX_BATCHES(2)) dut (
      .clk(clk), .rst_n(rst_n), .writeData(writeData), .botIn(botIn),
      .validPermsIn(validPermsIn), .batchDoneIn(batchDoneIn),
      .slowDownInput(slowDownInput), .fifoUsedw(fifoUsedw),
      .downstreamStall(downstreamStall), .outValid(outValid), .outBot(outBot),
      .outPermIdx(outPermIdx), .outLastOfBatch(outLastOfBatch),
      .resultRetired(resultRetired), .batchesInFlight(batchesInFlight),
      .errorSticky(errorSticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         vld;
      logic         last;
      logic [127:0] bot;
      logic [2:0]   idx;
      logic         chained;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   prev_cyc = 0;
   int   beats_seen = 0;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && (outValid || outLastOfBatch)) begin
         if (sb.size() == 0) begin
            chk("spurious", 192'({outValid, outLastOfBatch}), 192'(2'b00));
         end else begin
            e = sb.pop_front();
            if (e.vld)
               chk("beat", 192'({outValid, outLastOfBatch, outBot, outPermIdx}),
                   192'({e.vld, e.last, e.bot, e.idx}));
            else
               chk("marker", 192'({outValid, outLastOfBatch}), 192'({e.vld, e.last}));
            if (e.chained) chk("no_bubble", 192'(cyc - prev_cyc), 192'(1));
            prev_cyc = cyc;
            beats_seen++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_entry(input logic [127:0] b, input logic [5:0] m, input logic d,
                             input logic chain_first, input logic chain_rest);
      exp_t e;
      logic first;
      first = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (m[i]) begin
            e.vld     = 1'b1;
            e.last    = d && ((m >> (i + 1)) == 6'd0);
            e.bot     = b;
            e.idx     = 3'(i);
            e.chained = first ? chain_first : chain_rest;
            sb.push_back(e);
            first = 1'b0;
         end
      end
      if (m == 6'd0 && d) begin
         e.vld = 1'b0; e.last = 1'b1; e.bot = b; e.idx = 3'd0; e.chained = chain_first;
         sb.push_back(e);
      end
   endtask

   task automatic drive(input logic [127:0] b, input logic [5:0] m, input logic d);
      writeData = 1'b1; botIn = b; validPermsIn = m; batchDoneIn = d;
      tick();
      writeData = 1'b0; validPermsIn = '0; batchDoneIn = 1'b0;
   endtask

   task automatic retire();
      resultRetired = 1'b1;
      tick();
      resultRetired = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
      tick();
      chk(tag, 192'(sb.size()), 192'(0));
   endtask

   task automatic wait_beats(input string tag, input int target);
      for (int k = 0; k < 50 && beats_seen < target; k++) tick();
      chk(tag, 192'(beats_seen >= target), 192'(1));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int cnt;
      repeat (3) tick();
      chk("rst_valid", 192'(outValid), 192'(0));
      chk("rst_last", 192'(outLastOfBatch), 192'(0));
      chk("rst_bot", 192'(outBot), 192'(0));
      chk("rst_usedw", 192'(fifoUsedw), 192'(0));
      chk("rst_credits", 192'(batchesInFlight), 192'(0));
      chk("rst_err", 192'(errorSticky), 192'(0));
      chk("rst_slow", 192'(slowDownInput), 192'(0));
      rst_n = 1'b1;
      repeat (2) tick();

      // single entry, three ascending beats, no marker
      push_entry(128'hAAAA_0000_1111_2222_3333_4444_5555_6666, 6'b101001, 1'b0, 1'b0, 1'b1);
      drive(128'hAAAA_0000_1111_2222_3333_4444_5555_6666, 6'b101001, 1'b0);
      wait_drain("drain_single");
      chk("credits_nodone", 192'(batchesInFlight), 192'(0));

      // two entries chained into one batch
      push_entry(128'hBBBB, 6'b000011, 1'b0, 1'b0, 1'b1);
      push_entry(128'hCCCC, 6'b000100, 1'b1, 1'b1, 1'b1);
      drive(128'hBBBB, 6'b000011, 1'b0);
      drive(128'hCCCC, 6'b000100, 1'b1);
      wait_drain("drain_chain");
      chk("credits_chain", 192'(batchesInFlight), 192'(1));
      retire();
      chk("credits_retired", 192'(batchesInFlight), 192'(0));

      // empty-mask batch terminator
      push_entry(128'hDDDD, 6'b000000, 1'b1, 1'b0, 1'b0);
      drive(128'hDDDD, 6'b000000, 1'b1);
      wait_drain("drain_marker");
      chk("credits_marker", 192'(batchesInFlight), 192'(1));
      retire();
      retire();
      chk("retire_at_zero_err", 192'(errorSticky), 192'(2'b10));
      chk("retire_at_zero_cred", 192'(batchesInFlight), 192'(0));

      // credit exhaustion holds the third batch in the FIFO
      push_entry(128'hE1, 6'b000001, 1'b1, 1'b0, 1'b0);
      push_entry(128'hE2, 6'b000010, 1'b1, 1'b0, 1'b0);
      push_entry(128'hE3, 6'b000100, 1'b1, 1'b0, 1'b0);
      drive(128'hE1, 6'b000001, 1'b1);
      drive(128'hE2, 6'b000010, 1'b1);
      drive(128'hE3, 6'b000100, 1'b1);
      repeat (10) tick();
      chk("held_usedw", 192'(fifoUsedw), 192'(1));
      chk("held_credits", 192'(batchesInFlight), 192'(2));
      chk("held_pending", 192'(sb.size()), 192'(1));
      retire();
      chk("retire_credits", 192'(batchesInFlight), 192'(1));
      chk("retire_usedw", 192'(fifoUsedw), 192'(1));
      tick();
      chk("third_pops", 192'(outValid), 192'(1));
      chk("third_credits", 192'(batchesInFlight), 192'(2));
      chk("third_usedw", 192'(fifoUsedw), 192'(0));
      tick();
      retire();
      retire();
      chk("credits_zero", 192'(batchesInFlight), 192'(0));

      // fill the FIFO with the pipeline stalled
      downstreamStall = 1'b1;
      for (int i = 0; i < 33; i++) begin
         if (i < 32) push_entry(128'({16'hF1F1, 16'(i)}), 6'(6'b000001 << (i % 6)), 1'b0, 1'b0, 1'b0);
         drive(128'({16'hF1F1, 16'(i)}), 6'(6'b000001 << (i % 6)), 1'b0);
         if (i == 24) chk("slow_after_25", 192'(slowDownInput), 192'(0));
         if (i == 25) chk("slow_after_26", 192'(slowDownInput), 192'(1));
      end
      chk("full_usedw", 192'(fifoUsedw), 192'(32));
      chk("overflow_err", 192'(errorSticky), 192'(2'b11));
      downstreamStall = 1'b0;
      wait_drain("drain_fill");
      chk("slow_cleared", 192'(slowDownInput), 192'(0));

      // stall mid-burst, resume, then reset mid-burst
      cnt = beats_seen;
      push_entry(128'h5151, 6'b111111, 1'b0, 1'b0, 1'b0);
      drive(128'h5151, 6'b111111, 1'b0);
      wait_beats("wait_pre_stall", cnt + 2);
      downstreamStall = 1'b1;
      tick();
      chk("stall_valid", 192'({outValid, outLastOfBatch}), 192'(2'b00));
      cnt = beats_seen;
      repeat (2) tick();
      chk("stall_hold", 192'(beats_seen), 192'(cnt));
      chk("stall_valid_late", 192'(outValid), 192'(0));
      downstreamStall = 1'b0;
      wait_beats("wait_resume", cnt + 1);
      rst_n = 1'b0;
      tick();
      chk("midrst_outs", 192'({outValid, outLastOfBatch, outBot, outPermIdx}), 192'(0));
      chk("midrst_state", 192'({fifoUsedw, batchesInFlight, errorSticky, slowDownInput}), 192'(0));
      sb.delete();
      cnt = beats_seen;
      rst_n = 1'b1;
      repeat (10) tick();
      chk("aborted_burst", 192'(beats_seen), 192'(cnt));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
